// File: rtl/mau_arb_pkg.sv
// Shared types and helpers for the MAU command arbiter: widths, instruction layout
// and the round-robin winner search.
package mau_arb_pkg;

  localparam int unsigned INSTR_W = 40;
  localparam int unsigned RES_W   = 18;
  localparam int unsigned MAX_REQ = 4;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] b1;
    logic [7:0] b2;
  } instr_t;

  // First set bit of valid at or above ptr, wrapping modulo nreq; 0 when none is set.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned        ptr,
                                          input int unsigned        nreq);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = (ptr + i) % nreq;
      if (!found && (i < nreq) && valid[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mau_cmd_arbiter_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight MAU instruction.
module mau_tag_fifo #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  // Depth is a power of two, so pointers wrap naturally; the extra count bit separates full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/mau_cmd_arbiter.sv
// Round-robin arbiter sharing the MAU pipeline between NREQ requesters, with in-order
// result routing. Optional per-requester issue counters behind MAU_ARB_STATS_EN.
module mau_cmd_arbiter
  import mau_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*INSTR_W-1:0]   req_instr,
  output logic [NREQ-1:0]           req_ready,
  output logic                      cmd_valid,
  output logic [INSTR_W-1:0]        cmd_instr,
  input  logic                      cmd_ready,
  input  logic                      res_valid_in,
  input  logic [RES_W-1:0]          res_data_in,
  input  logic                      res_carry_in,
  output logic                      res_ready_out,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [RES_W-1:0]          rsp_data,
  output logic                      rsp_carry,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [$clog2(TAG_DEPTH):0] inflight,
  output logic                      orphan_err
`ifdef MAU_ARB_STATS_EN
  ,
  output logic [NREQ*8-1:0]         issue_cnt
`endif
);

  localparam int unsigned TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

  typedef enum logic {IDLE, HOLD} state_e;

  state_e           state_q, state_d;
  instr_t           cmd_instr_q, cmd_instr_d;
  logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d, win_tag, head;
  logic             orphan_q, orphan_d;
  logic [CNT_W-1:0] count;
  logic [MAX_REQ-1:0] valid_pad;
  logic             grant, fifo_empty, pop;
  int unsigned      win;

  always_comb begin
    valid_pad            = '0;
    valid_pad[NREQ-1:0]  = req_valid;
    win                  = rr_pick(valid_pad, 32'(rr_ptr_q), NREQ);
    win_tag              = TAG_W'(win);
    // Slot frees on the same-cycle handshake; occupancy uses the registered count only.
    grant = !rst && ((state_q == IDLE) || cmd_ready) &&
            (count < CNT_W'(TAG_DEPTH)) && (|req_valid);

    req_ready   = '0;
    cmd_instr_d = cmd_instr_q;
    rr_ptr_d    = rr_ptr_q;
    state_d     = state_q;
    if (grant) begin
      req_ready[win_tag] = 1'b1;
      cmd_instr_d        = req_instr[win*INSTR_W +: INSTR_W];
      rr_ptr_d           = TAG_W'((win + 1) % NREQ);
      state_d            = HOLD;
    end else if ((state_q == HOLD) && cmd_ready) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    fifo_empty      = (count == '0);
    rsp_valid       = '0;
    rsp_valid[head] = res_valid_in && !fifo_empty;
    res_ready_out   = !fifo_empty && rsp_ready[head];
    pop             = res_valid_in && res_ready_out;
    orphan_d        = orphan_q || (res_valid_in && fifo_empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_instr_q <= '0;
      rr_ptr_q    <= '0;
      orphan_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_instr_q <= cmd_instr_d;
      rr_ptr_q    <= rr_ptr_d;
      orphan_q    <= orphan_d;
    end
  end

  mau_tag_fifo #(
    .W     (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (grant),
    .pop_i   (pop),
    .din_i   (win_tag),
    .head_o  (head),
    .count_o (count)
  );

  assign cmd_valid  = (state_q == HOLD);
  assign cmd_instr  = cmd_instr_q;
  assign rsp_data   = res_data_in;
  assign rsp_carry  = res_carry_in;
  assign inflight   = count;
  assign orphan_err = orphan_q;

`ifdef MAU_ARB_STATS_EN
  for (genvar g = 0; g < NREQ; g++) begin : g_stats
    logic [7:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                           cnt_q <= '0;
      else if (req_ready[g] && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
    assign issue_cnt[g*8 +: 8] = cnt_q;
  end
`endif

endmodule
